mult_sequencer: RTL and testbench

Controller that sequences the shift-add 32x32 multiplier datapath on behalf of the CPU control unit. It accepts MULT/MULTU requests and converts signed operands to magnitudes. It drives the multiplier's state input through INIT/WORK/IDLE, applies the sign correction to the 64-bit product, and holds the architectural HI/LO registers, including the MTHI/MTLO write path. It sits between the main control FSM and the multiplier, and presents a busy/done handshake so that control can stall.

---
 rtl/mult_sequencer.sv | 151 +++++++++++++++
 tb/tb_mult_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_sequencer.sv
// mult_sequencer: control FSM around an external shift-add 32x32 multiplier.
// Accepts MULT/MULTU requests, feeds operand magnitudes to the multiplier, applies
// the sign correction to the 64-bit product and owns the architectural HI/LO registers
// (including the MTHI/MTLO write path). busy/done let the main control unit stall.
module mult_sequencer #(
  parameter logic [5:0] MULT_IDLE  = 6'd0,
  parameter logic [5:0] MULT_INIT  = 6'd1,
  parameter logic [5:0] MULT_WORK  = 6'd2,
  parameter logic [5:0] MULT_STEPS = 6'd32
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [5:0]  mult_state,
  output logic [31:0] mult_lhs,
  output logic [31:0] mult_rhs,
  input  logic [63:0] mult_result,
  input  logic [5:0]  mult_counter,
  input  logic        mult_end
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [5:0]  mult_state_q, mult_state_d;
  logic [31:0] lhs_q, lhs_d;
  logic [31:0] rhs_q, rhs_d;
  logic        neg_q, neg_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        accept;
  logic        prod_wr;
  logic        mt_ok;
  logic [63:0] prod_fixed;

  // The multiplier raises its own end flag; sequencing relies on mult_counter only.
  logic unused_mult_end;
  assign unused_mult_end = mult_end;

  // Two's complement magnitude; 0x80000000 maps to itself, read as unsigned 2^31.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

  // Decode the request, product-write and MTHI/MTLO qualifiers.
  always_comb begin
    accept     = (state_q == S_IDLE) && start;
    prod_wr    = (state_q == S_RUN) && (mult_counter == MULT_STEPS);
    mt_ok      = (state_q == S_IDLE) && !start;
    prod_fixed = neg_q ? (~mult_result + 64'd1) : mult_result;
  end

  // Next-state logic for the sequencing FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  state_d = S_RUN;
      S_RUN:   if (mult_counter == MULT_STEPS) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs follow the next state so they line up with the FSM.
  always_comb begin
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
    mult_state_d = MULT_IDLE;
    unique case (state_d)
      S_LOAD:  mult_state_d = MULT_INIT;
      S_RUN:   mult_state_d = MULT_WORK;
      default: mult_state_d = MULT_IDLE;
    endcase
  end

  // Operand magnitudes and negate flag are captured on an accepted start.
  always_comb begin
    lhs_d = lhs_q;
    rhs_d = rhs_q;
    neg_d = neg_q;
    if (accept) begin
      lhs_d = magnitude(a, is_signed);
      rhs_d = magnitude(b, is_signed);
      neg_d = is_signed & (a[31] ^ b[31]);
    end
  end

  // HI/LO: product write wins; MTHI/MTLO only when idle and no start this cycle.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (prod_wr) begin
      hi_d = prod_fixed[63:32];
      lo_d = prod_fixed[31:0];
    end else if (mt_ok) begin
      if (hi_we) hi_d = wdata;
      if (lo_we) lo_d = wdata;
    end
  end

  // State registers; reset discards any in-flight product.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mult_state_q <= MULT_IDLE;
      lhs_q        <= 32'd0;
      rhs_q        <= 32'd0;
      neg_q        <= 1'b0;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      mult_state_q <= mult_state_d;
      lhs_q        <= lhs_d;
      rhs_q        <= rhs_d;
      neg_q        <= neg_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign mult_state = mult_state_q;
  assign mult_lhs   = lhs_q;
  assign mult_rhs   = rhs_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: a behavioural multiplier sits on the datapath side, and
// results are compared against plain 64-bit arithmetic on the original operands.
module tb_mult_sequencer;

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done;
  logic [31:0] hi, lo, mult_lhs, mult_rhs;
  logic [5:0]  mult_state;
  logic [63:0] mult_result = '0;
  logic [5:0]  mult_counter = '0;
  logic        mult_end;
  logic [31:0] m_lhs = '0;
  logic [31:0] m_rhs = '0;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  mult_sequencer dut (
    .Clk          (Clk),
    .reset        (reset),
    .start        (start),
    .is_signed    (is_signed),
    .a            (a),
    .b            (b),
    .hi_we        (hi_we),
    .lo_we        (lo_we),
    .wdata        (wdata),
    .busy         (busy),
    .done         (done),
    .hi           (hi),
    .lo           (lo),
    .mult_state   (mult_state),
    .mult_lhs     (mult_lhs),
    .mult_rhs     (mult_rhs),
    .mult_result  (mult_result),
    .mult_counter (mult_counter),
    .mult_end     (mult_end)
  );

  // Multiplier model: INIT loads, each WORK step counts, product valid at count 32.
  assign mult_end = (mult_counter == 6'd32);
  always @(posedge Clk) begin
    if (mult_state == 6'd1) begin
      m_lhs        <= mult_lhs;
      m_rhs        <= mult_rhs;
      mult_counter <= 6'd0;
      mult_result  <= 64'd0;
    end else if (mult_state == 6'd2 && mult_counter < 6'd32) begin
      mult_counter <= mult_counter + 6'd1;
      if (mult_counter == 6'd31) mult_result <= {32'd0, m_lhs} * {32'd0, m_rhs};
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y,
                                           input logic sgn);
    longint sx, sy;
    if (sgn) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    return {32'd0, x} * {32'd0, y};
  endfunction

  function automatic logic [31:0] ref_mag(input logic [31:0] x, input logic sgn);
    longint sx;
    sx = sgn ? longint'($signed(x)) : longint'({32'd0, x});
    return 32'(sx < 0 ? -sx : sx);
  endfunction

  // One full product from the idle state. mthi_at/restart_at pick a busy cycle in
  // which to inject MTHI or a stray start (-1 = none); mt_with_start adds hi_we at start.
  task automatic run_product(input logic [31:0] op_a, input logic [31:0] op_b,
                             input logic sgn, input int mthi_at, input int restart_at,
                             input bit mt_with_start);
    logic [63:0] exp;
    logic [31:0] hi0, lo0;
    exp = ref_prod(op_a, op_b, sgn);
    hi0 = hi;
    lo0 = lo;
    a = op_a; b = op_b; is_signed = sgn; start = 1'b1;
    hi_we = mt_with_start; wdata = 32'h5A5A_0F0F;
    tick();  // edge N
    start = 1'b0; hi_we = 1'b0;
    chk("busy_at_N", busy, 1);
    chk("state_at_N", mult_state, 6'd1);
    chk("lhs_mag", mult_lhs, ref_mag(op_a, sgn));
    chk("rhs_mag", mult_rhs, ref_mag(op_b, sgn));
    chk("hi_hold_N", hi, hi0);
    for (int k = 1; k <= 33; k++) begin
      tick();  // edge N+k
      chk("busy_run", busy, 1);
      chk("done_low_run", done, 0);
      chk("state_run", mult_state, 6'd2);
      chk("hi_hold_run", {hi, lo}, {hi0, lo0});
      hi_we = (k == mthi_at);
      wdata = 32'h1234_5678;
      start = (k == restart_at);
      if (k == restart_at) begin
        a = $urandom; b = $urandom; is_signed = 1'($urandom);
      end
    end
    hi_we = 1'b0; start = 1'b0;
    tick();  // edge N+34
    chk("done_N34", done, 1);
    chk("busy_N34", busy, 1);
    chk("state_N34", mult_state, 6'd0);
    chk("product", {hi, lo}, exp);
    tick();  // edge N+35
    chk("done_N35", done, 0);
    chk("busy_N35", busy, 0);
    chk("lhs_hold", mult_lhs, ref_mag(op_a, sgn));
    tick();
    chk("idle_after", busy, 0);
    chk("product_hold", {hi, lo}, exp);
  endtask

  initial begin
    #1 reset = 1'b0;
    #1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_state", mult_state, 0);
    chk("rst_lhs", {mult_lhs, mult_rhs}, 0);
    #10 reset = 1'b1;
    tick();

    run_product(32'd7, 32'd6, 1'b0, -1, -1, 1'b0);
    chk("u7x6_hi", hi, 32'h0);
    chk("u7x6_lo", lo, 32'h2A);
    run_product(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, -1, 1'b0);
    chk("uffff_hi", hi, 32'hFFFF_FFFE);
    run_product(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, -1, -1, 1'b0);
    chk("sm1_lo", lo, 32'h1);
    run_product(32'hFFFF_FFFD, 32'h5, 1'b1, -1, -1, 1'b0);
    chk("sm3x5", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_product(32'h8000_0000, 32'h8000_0000, 1'b1, -1, -1, 1'b0);
    chk("smin_sq", {hi, lo}, 64'h4000_0000_0000_0000);
    run_product(32'h0, 32'hFFFF_FFF0, 1'b1, -1, -1, 1'b0);

    // MTHI during RUN is ignored; stray start while busy is dropped.
    run_product(32'h0001_2345, 32'hFFFF_0001, 1'b1, 11, -1, 1'b0);
    run_product(32'hDEAD_BEEF, 32'h0000_1001, 1'b0, -1, 20, 1'b1);

    // MTLO / MTHI in idle.
    lo_we = 1'b1; wdata = 32'hCAFE_BABE;
    tick();
    lo_we = 1'b0;
    chk("mtlo", lo, 32'hCAFE_BABE);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0BAD_F00D;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mthi_mtlo", {hi, lo}, 64'h0BAD_F00D_0BAD_F00D);

    for (int i = 0; i < 10; i++) begin
      run_product($urandom, $urandom, 1'($urandom), -1, -1, 1'b0);
    end

    // Reset in the middle of RUN.
    a = 32'd9; b = 32'd9; is_signed = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 16; k++) tick();
    chk("pre_rst_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_hilo", {hi, lo}, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_state", mult_state, 0);
    #2 reset = 1'b1;
    tick();
    run_product(32'd7, 32'd6, 1'b0, -1, -1, 1'b0);
    chk("post_rst_7x6", {hi, lo}, 64'd42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
